// File: rtl/battle_sequencer.sv
// Battle turn controller: player HP, NUM_MON monster HP counters, menu/target
// selection from key edges. Optional macro BATTLE_HEAL_EN enables healing on dmg_valid.
module battle_sequencer #(
  parameter int HP_W       = 8,
  parameter int NUM_MON    = 2,
  parameter int MAX_HP     = 100,
  parameter int PLAYER_ATK = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              keyboard,
  input  logic                    atk_done,
  input  logic                    atk_pass,
  input  logic                    dmg_valid,
  input  logic [HP_W-1:0]         damage,
  input  logic                    heal,
  input  logic                    dodge_done,
  output logic [7:0]              state,
  output logic [HP_W-1:0]         player_hp,
  output logic [NUM_MON*HP_W-1:0] mon_hp,
  output logic [2:0]              target,
  output logic                    is_move,
  output logic                    start_dmg,
  output logic                    is_death,
  output logic                    is_win
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MENU   = 3'd1,
    S_TARGET = 3'd2,
    S_ATTACK = 3'd3,
    S_DODGE  = 3'd4,
    S_DEAD   = 3'd5,
    S_WIN    = 3'd6
  } state_e;

  localparam logic [3:0] KEY_LEFT    = 4'b0001;
  localparam logic [3:0] KEY_RIGHT   = 4'b0010;
  localparam logic [3:0] KEY_CONFIRM = 4'b0011;
  localparam logic [3:0] KEY_CANCEL  = 4'b0100;
  localparam logic [3:0] KEY_START   = 4'b1000;

  localparam logic [HP_W-1:0] HP_FULL  = HP_W'(MAX_HP);
  localparam logic [HP_W-1:0] ATK_FULL = HP_W'(PLAYER_ATK);
  localparam logic [HP_W-1:0] ATK_HALF = HP_W'(PLAYER_ATK >> 1);
  localparam logic [2:0]      TGT_LAST = 3'(NUM_MON - 1);

  state_e          state_q, state_d;
  logic [3:0]      key_prev_q;
  logic [HP_W-1:0] player_hp_q, player_hp_d;
  logic [HP_W-1:0] mon_hp_q [NUM_MON];
  logic [HP_W-1:0] mon_hp_d [NUM_MON];
  logic [2:0]      target_q, target_d;
  logic            is_move_q, start_dmg_q, is_death_q, is_win_q;
  logic [3:0]      key;
  logic            tgt_alive;
  logic            all_dead;
  logic [HP_W-1:0] atk_amt;

  function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] a,
                                              input logic [HP_W-1:0] b);
    return (a > b) ? (a - b) : '0;
  endfunction

`ifdef BATTLE_HEAL_EN
  function automatic logic [HP_W-1:0] sat_add_max(input logic [HP_W-1:0] a,
                                                  input logic [HP_W-1:0] b);
    logic [HP_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, HP_FULL}) ? HP_FULL : sum[HP_W-1:0];
  endfunction
`else
  logic heal_unused;
  assign heal_unused = heal;
`endif

  // Only the first cycle of a press produces a key; held keys read as none.
  always_comb begin
    key = ((keyboard != 4'd0) && (key_prev_q == 4'd0)) ? keyboard : 4'd0;
  end

  always_comb begin
    state_d     = state_q;
    player_hp_d = player_hp_q;
    target_d    = target_q;
    all_dead    = 1'b0;
    tgt_alive   = 1'b0;
    atk_amt     = atk_pass ? ATK_FULL : ATK_HALF;
    for (int i = 0; i < NUM_MON; i++) begin
      mon_hp_d[i] = mon_hp_q[i];
      if (3'(i) == target_q && mon_hp_q[i] != '0) tgt_alive = 1'b1;
    end

    case (state_q)
      S_IDLE, S_DEAD, S_WIN: begin
        if (key == KEY_START) begin
          state_d     = S_MENU;
          player_hp_d = HP_FULL;
          target_d    = 3'd0;
          for (int i = 0; i < NUM_MON; i++) mon_hp_d[i] = HP_FULL;
        end
      end
      S_MENU: begin
        if (key == KEY_CONFIRM)     state_d = S_TARGET;
        else if (key == KEY_CANCEL) state_d = S_DODGE;
      end
      S_TARGET: begin
        if (key == KEY_LEFT)
          target_d = (target_q == 3'd0) ? TGT_LAST : target_q - 3'd1;
        else if (key == KEY_RIGHT)
          target_d = (target_q == TGT_LAST) ? 3'd0 : target_q + 3'd1;
        else if (key == KEY_CONFIRM && tgt_alive)
          state_d = S_ATTACK;
        else if (key == KEY_CANCEL)
          state_d = S_MENU;
      end
      S_ATTACK: begin
        if (atk_done) begin
          all_dead = 1'b1;
          for (int i = 0; i < NUM_MON; i++) begin
            if (3'(i) == target_q) mon_hp_d[i] = sat_sub(mon_hp_q[i], atk_amt);
            if (mon_hp_d[i] != '0) all_dead = 1'b0;
          end
          state_d = all_dead ? S_WIN : S_DODGE;
        end
      end
      S_DODGE: begin
        if (dmg_valid) begin
`ifdef BATTLE_HEAL_EN
          player_hp_d = heal ? sat_add_max(player_hp_q, damage)
                             : sat_sub(player_hp_q, damage);
`else
          player_hp_d = sat_sub(player_hp_q, damage);
`endif
        end
        // Death outranks a simultaneous dodge_done.
        if (player_hp_d == '0) state_d = S_DEAD;
        else if (dodge_done)   state_d = S_MENU;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      key_prev_q  <= 4'd0;
      player_hp_q <= '0;
      target_q    <= 3'd0;
      is_move_q   <= 1'b0;
      start_dmg_q <= 1'b0;
      is_death_q  <= 1'b0;
      is_win_q    <= 1'b0;
      for (int i = 0; i < NUM_MON; i++) mon_hp_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      key_prev_q  <= keyboard;
      player_hp_q <= player_hp_d;
      target_q    <= target_d;
      is_move_q   <= (state_d == S_DODGE);
      start_dmg_q <= (state_d == S_DODGE) && (state_q != S_DODGE);
      is_death_q  <= (state_d == S_DEAD);
      is_win_q    <= (state_d == S_WIN);
      for (int i = 0; i < NUM_MON; i++) mon_hp_q[i] <= mon_hp_d[i];
    end
  end

  for (genvar g = 0; g < NUM_MON; g++) begin : g_mon_out
    assign mon_hp[g*HP_W +: HP_W] = mon_hp_q[g];
  end

  assign state     = {5'd0, state_q};
  assign player_hp = player_hp_q;
  assign target    = target_q;
  assign is_move   = is_move_q;
  assign start_dmg = start_dmg_q;
  assign is_death  = is_death_q;
  assign is_win    = is_win_q;

endmodule

// File: tb/tb_battle_sequencer.sv
// Directed bench for battle_sequencer (defaults: HP_W=8, NUM_MON=2, MAX_HP=100, PLAYER_ATK=10).
module tb_battle_sequencer;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  keyboard;
  logic        atk_done, atk_pass, dmg_valid, heal, dodge_done;
  logic [7:0]  damage;
  logic [7:0]  state;
  logic [7:0]  player_hp;
  logic [15:0] mon_hp;
  logic [2:0]  target;
  logic        is_move, start_dmg, is_death, is_win;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_hp;

  localparam logic [3:0] K_LEFT = 4'b0001, K_RIGHT = 4'b0010, K_CONFIRM = 4'b0011,
                         K_CANCEL = 4'b0100, K_START = 4'b1000;

  battle_sequencer dut (
    .clk(clk), .reset(reset), .keyboard(keyboard), .atk_done(atk_done),
    .atk_pass(atk_pass), .dmg_valid(dmg_valid), .damage(damage), .heal(heal),
    .dodge_done(dodge_done), .state(state), .player_hp(player_hp), .mon_hp(mon_hp),
    .target(target), .is_move(is_move), .start_dmg(start_dmg), .is_death(is_death),
    .is_win(is_win)
  );

  always #5 clk = ~clk;

  task automatic key(input logic [3:0] k);
    keyboard = k;
    @(negedge clk);
    keyboard = 4'd0;
    @(negedge clk);
  endtask

  task automatic atk(input logic pass);
    atk_done = 1'b1; atk_pass = pass;
    @(negedge clk);
    atk_done = 1'b0; atk_pass = 1'b0;
  endtask

  task automatic dmg(input logic [7:0] amt, input logic h, input logic dd);
    dmg_valid = 1'b1; damage = amt; heal = h; dodge_done = dd;
    @(negedge clk);
    dmg_valid = 1'b0; damage = 8'd0; heal = 1'b0; dodge_done = 1'b0;
  endtask

  task automatic dodge_end();
    dodge_done = 1'b1;
    @(negedge clk);
    dodge_done = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; keyboard = 4'd0; atk_done = 0; atk_pass = 0;
    dmg_valid = 0; heal = 0; dodge_done = 0; damage = 8'd0;
    repeat (2) @(negedge clk);
    checks++; if (state !== 8'd0) begin failures++; $display("FAIL rst_state got %0d want 0", state); end
    checks++; if (player_hp !== 8'd0) begin failures++; $display("FAIL rst_php got %0d want 0", player_hp); end
    checks++; if (mon_hp !== 16'd0) begin failures++; $display("FAIL rst_mon got %h want 0000", mon_hp); end
    checks++; if (target !== 3'd0) begin failures++; $display("FAIL rst_target got %0d want 0", target); end
    checks++; if ({is_move, start_dmg, is_death, is_win} !== 4'b0) begin failures++; $display("FAIL rst_flags got %b want 0000", {is_move, start_dmg, is_death, is_win}); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_attack();
    key(K_START);
    checks++; if (state !== 8'd1) begin failures++; $display("FAIL start_state got %0d want 1", state); end
    checks++; if (player_hp !== 8'd100) begin failures++; $display("FAIL start_php got %0d want 100", player_hp); end
    checks++; if (mon_hp !== 16'h6464) begin failures++; $display("FAIL start_mon got %h want 6464", mon_hp); end
    key(K_CONFIRM);
    checks++; if (state !== 8'd2) begin failures++; $display("FAIL menu_confirm got %0d want 2", state); end
    key(K_CONFIRM);
    checks++; if (state !== 8'd3) begin failures++; $display("FAIL tgt_confirm got %0d want 3", state); end
    atk(1'b1);
    checks++; if (state !== 8'd4) begin failures++; $display("FAIL atk_state got %0d want 4", state); end
    checks++; if (mon_hp !== 16'h645A) begin failures++; $display("FAIL atk_full got %h want 645a", mon_hp); end
    checks++; if ({start_dmg, is_move} !== 2'b11) begin failures++; $display("FAIL dodge_entry got %b want 11", {start_dmg, is_move}); end
    @(negedge clk);
    checks++; if ({start_dmg, is_move} !== 2'b01) begin failures++; $display("FAIL dodge_hold got %b want 01", {start_dmg, is_move}); end
  endtask

  task automatic test_dodge();
    dmg(8'd5, 1'b0, 1'b0);
    checks++; if (player_hp !== 8'd95) begin failures++; $display("FAIL dmg5 got %0d want 95", player_hp); end
    dmg(8'd20, 1'b1, 1'b0);
`ifdef BATTLE_HEAL_EN
    exp_hp = 8'd100;
`else
    exp_hp = 8'd75;
`endif
    checks++; if (player_hp !== exp_hp) begin failures++; $display("FAIL heal20 got %0d want %0d", player_hp, exp_hp); end
    dodge_end();
    checks++; if ({state, is_move} !== {8'd1, 1'b0}) begin failures++; $display("FAIL dodge_done got %0d/%b want 1/0", state, is_move); end
  endtask

  task automatic test_target_nav();
    key(K_CONFIRM);
    checks++; if (target !== 3'd0) begin failures++; $display("FAIL nav_init got %0d want 0", target); end
    key(K_LEFT);
    checks++; if (target !== 3'd1) begin failures++; $display("FAIL nav_left_wrap got %0d want 1", target); end
    key(K_RIGHT);
    checks++; if (target !== 3'd0) begin failures++; $display("FAIL nav_right_wrap got %0d want 0", target); end
    keyboard = K_RIGHT;
    repeat (3) @(negedge clk);
    keyboard = 4'd0;
    @(negedge clk);
    checks++; if (target !== 3'd1) begin failures++; $display("FAIL nav_held got %0d want 1", target); end
    key(K_LEFT);
    key(K_CANCEL);
    checks++; if ({state, target} !== {8'd1, 3'd0}) begin failures++; $display("FAIL nav_cancel got %0d/%0d want 1/0", state, target); end
  endtask

  task automatic test_death();
    key(K_CANCEL);
    checks++; if ({state, is_move} !== {8'd4, 1'b1}) begin failures++; $display("FAIL skip_turn got %0d/%b want 4/1", state, is_move); end
    dmg(exp_hp - 8'd3, 1'b0, 1'b0);
    checks++; if ({state, player_hp} !== {8'd4, 8'd3}) begin failures++; $display("FAIL hp3 got %0d/%0d want 4/3", state, player_hp); end
    dmg(8'd5, 1'b0, 1'b1);
    checks++; if (player_hp !== 8'd0) begin failures++; $display("FAIL death_hp got %0d want 0", player_hp); end
    checks++; if ({state, is_death, is_move} !== {8'd5, 1'b1, 1'b0}) begin failures++; $display("FAIL death_state got %0d/%b/%b want 5/1/0", state, is_death, is_move); end
    key(K_CONFIRM);
    atk(1'b1);
    checks++; if ({state, mon_hp} !== {8'd5, 16'h645A}) begin failures++; $display("FAIL dead_ignore got %0d/%h want 5/645a", state, mon_hp); end
  endtask

  task automatic test_win();
    key(K_START);
    checks++; if ({state, player_hp, mon_hp, is_death} !== {8'd1, 8'd100, 16'h6464, 1'b0}) begin failures++; $display("FAIL restart got %0d/%0d/%h/%b want 1/100/6464/0", state, player_hp, mon_hp, is_death); end
    for (int i = 0; i < 20; i++) begin
      key(K_CONFIRM);
      key(K_CONFIRM);
      atk(1'b0);
      if (i == 0) begin
        checks++; if (mon_hp !== 16'h645F) begin failures++; $display("FAIL atk_half got %h want 645f", mon_hp); end
      end
      if (i < 19) dodge_end();
    end
    checks++; if ({state, mon_hp} !== {8'd4, 16'h6400}) begin failures++; $display("FAIL mon0_dead got %0d/%h want 4/6400", state, mon_hp); end
    dodge_end();
    key(K_CONFIRM);
    key(K_CONFIRM);
    checks++; if (state !== 8'd2) begin failures++; $display("FAIL dead_target got %0d want 2", state); end
    key(K_RIGHT);
    key(K_CONFIRM);
    checks++; if ({state, target} !== {8'd3, 3'd1}) begin failures++; $display("FAIL mon1_attack got %0d/%0d want 3/1", state, target); end
    for (int i = 0; i < 20; i++) begin
      if (i > 0) begin
        key(K_CONFIRM);
        key(K_CONFIRM);
      end
      atk(1'b0);
      if (i < 19) dodge_end();
    end
    checks++; if ({state, mon_hp} !== {8'd6, 16'h0000}) begin failures++; $display("FAIL win got %0d/%h want 6/0000", state, mon_hp); end
    checks++; if ({is_win, is_move, start_dmg} !== 3'b100) begin failures++; $display("FAIL win_flags got %b want 100", {is_win, is_move, start_dmg}); end
    key(K_CONFIRM);
    checks++; if (state !== 8'd6) begin failures++; $display("FAIL win_ignore got %0d want 6", state); end
  endtask

  task automatic test_reset_mid();
    key(K_START);
    checks++; if ({state, player_hp, mon_hp, target, is_win} !== {8'd1, 8'd100, 16'h6464, 3'd0, 1'b0}) begin failures++; $display("FAIL win_restart got %0d/%0d/%h/%0d/%b", state, player_hp, mon_hp, target, is_win); end
    key(K_CONFIRM);
    key(K_CONFIRM);
    checks++; if (state !== 8'd3) begin failures++; $display("FAIL pre_reset got %0d want 3", state); end
    #2 reset = 1'b1;
    #1;
    checks++; if ({state, player_hp, mon_hp, target} !== {8'd0, 8'd0, 16'd0, 3'd0}) begin failures++; $display("FAIL async_reset got %0d/%0d/%h/%0d want 0/0/0/0", state, player_hp, mon_hp, target); end
    checks++; if ({is_move, start_dmg, is_death, is_win} !== 4'b0) begin failures++; $display("FAIL async_flags got %b want 0000", {is_move, start_dmg, is_death, is_win}); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    key(K_START);
    checks++; if ({state, player_hp, mon_hp} !== {8'd1, 8'd100, 16'h6464}) begin failures++; $display("FAIL post_reset got %0d/%0d/%h want 1/100/6464", state, player_hp, mon_hp); end
  endtask

  initial begin
    test_reset();
    test_attack();
    test_dodge();
    test_target_nav();
    test_death();
    test_win();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
